// File: rtl/hazard_ctrl_pkg.sv
// core_pkg: shared types and constants for the pipeline hazard scheduler.
package core_pkg;
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} hz_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side view of the hazard unit (hazard sources in, stage controls out).
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0]       ID_EX_rs1;
    logic [4:0]       ID_EX_rs2;
    logic             ID_EX_use_rs2;
    logic             EX_MEM_regwrite;
    logic             EX_MEM_memread;
    logic [4:0]       EX_MEM_rd;
    logic             dmem_req;
    logic             dmem_ready;
    logic             branch_taken;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout_err;
    modport master (
        input  ID_EX_rs1, ID_EX_rs2, ID_EX_use_rs2, EX_MEM_regwrite, EX_MEM_memread, EX_MEM_rd,
               dmem_req, dmem_ready, branch_taken,
        output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble,
               stall_cycles, mem_timeout_err
    );
    modport slave (
        output ID_EX_rs1, ID_EX_rs2, ID_EX_use_rs2, EX_MEM_regwrite, EX_MEM_memread, EX_MEM_rd,
               dmem_req, dmem_ready, branch_taken,
        input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble,
               stall_cycles, mem_timeout_err
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; clear wins over increment.
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign q_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble insertion, data-memory freeze and branch flush for the 5-stage core.
module hazard_ctrl import core_pkg::*; #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.master hz
);
    localparam int            WW       = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT - 1);
    localparam logic [WW-1:0] ERR_AT   = MEM_TIMEOUT > 1 ? WW'(MEM_TIMEOUT - 2) : '0;

    hz_state_t     state_q, state_d;
    logic          load_use, mem_stall, freeze, lu, br, err_q, err_d;
    logic [WW-1:0] wait_q;

    always_comb begin
        load_use  = hz.EX_MEM_memread & hz.EX_MEM_regwrite & (hz.EX_MEM_rd != REG_ZERO) &
                    ((hz.EX_MEM_rd == hz.ID_EX_rs1) | (hz.ID_EX_use_rs2 & (hz.EX_MEM_rd == hz.ID_EX_rs2)));
        mem_stall = hz.dmem_req & ~hz.dmem_ready;
        // an outstanding access keeps the freeze until ready, whatever the request line does
        freeze    = mem_stall | ((state_q == MEM_WAIT) & ~hz.dmem_ready);
        lu        = load_use & (state_q != LOAD_STALL) & ~freeze;
        br        = hz.branch_taken & ~freeze & ~lu;
        state_d   = freeze ? MEM_WAIT : lu ? LOAD_STALL : RUN;
        // the counter is about to reach MEM_TIMEOUT-1 (or already sits there)
        err_d     = err_q | (freeze & (wait_q >= ERR_AT));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end

    sat_counter #(.W(WW)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (freeze & (wait_q != WAIT_MAX)),
        .clr_i (~freeze),
        .q_o   (wait_q)
    );

    sat_counter #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (freeze | lu),
        .clr_i (1'b0),
        .q_o   (hz.stall_cycles)
    );

    assign hz.pc_en           = ~rst_n | ~(freeze | lu);
    assign hz.if_id_en        = hz.pc_en;
    assign hz.id_ex_en        = hz.pc_en;
    assign hz.ex_mem_bubble   = rst_n & lu;
    assign hz.if_id_flush     = rst_n & br;
    assign hz.id_ex_flush     = rst_n & br;
    assign hz.mem_timeout_err = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int TO = 4, CW = 6, SMAX = (1 << CW) - 1;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz();
    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .hz(hz.master));

    int errors = 0, checks = 0;
    bit m_wait, m_bub, m_err, m_frz, m_lu, e_stall, e_bub, e_br;
    int m_len, m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: a memory wait is pending, a bubble was just inserted, cycles waited, stalls seen
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_wait = 0; m_bub = 0; m_err = 0; m_len = 0; m_stalls = 0;
            m_frz = 0; m_lu = 0; e_stall = 0; e_bub = 0; e_br = 0;
        end else begin
            m_frz   = !hz.dmem_ready && (hz.dmem_req || m_wait);
            m_lu    = !m_bub && !m_frz && hz.EX_MEM_memread && hz.EX_MEM_regwrite && hz.EX_MEM_rd != 0 &&
                      (hz.EX_MEM_rd == hz.ID_EX_rs1 || (hz.ID_EX_use_rs2 && hz.EX_MEM_rd == hz.ID_EX_rs2));
            e_br    = hz.branch_taken && !m_frz && !m_lu;
            e_stall = m_frz || m_lu;
            e_bub   = m_lu;
        end
        chk("m_pc_en", hz.pc_en, !e_stall);
        chk("m_if_id_en", hz.if_id_en, !e_stall);
        chk("m_id_ex_en", hz.id_ex_en, !e_stall);
        chk("m_bubble", hz.ex_mem_bubble, e_bub);
        chk("m_if_id_flush", hz.if_id_flush, e_br);
        chk("m_id_ex_flush", hz.id_ex_flush, e_br);
        chk("m_stall_cycles", hz.stall_cycles, m_stalls);
        chk("m_timeout_err", hz.mem_timeout_err, m_err);
        if (rst_n) begin
            if (m_frz) begin
                if (m_len + 1 >= TO - 1) m_err = 1;
                m_len = (m_len + 1 > TO - 1) ? TO - 1 : m_len + 1;
            end else m_len = 0;
            m_wait = m_frz;
            m_bub  = m_lu;
            if (e_stall && m_stalls < SMAX) m_stalls++;
        end
    end

    task automatic set_in(input int rs1, rs2, u2, ld, rd, req, rdy, br);
        hz.ID_EX_rs1 = 5'(rs1); hz.ID_EX_rs2 = 5'(rs2); hz.ID_EX_use_rs2 = u2[0];
        hz.EX_MEM_memread = ld[0]; hz.EX_MEM_regwrite = ld[0]; hz.EX_MEM_rd = 5'(rd);
        hz.dmem_req = req[0]; hz.dmem_ready = rdy[0]; hz.branch_taken = br[0];
    endtask

    task automatic drive(input int rs1, rs2, u2, ld, rd, req, rdy, br);
        @(posedge clk); #1;
        set_in(rs1, rs2, u2, ld, rd, req, rdy, br);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("rst_pc_en", hz.pc_en, 1);
        chk("rst_stall_cycles", hz.stall_cycles, 0);
        chk("rst_err", hz.mem_timeout_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int burst;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        drive(5, 0, 0, 1, 5, 0, 1, 0);
        chk("lu_rs1_pc_en", hz.pc_en, 0);
        chk("lu_rs1_bubble", hz.ex_mem_bubble, 1);
        drive(5, 0, 0, 0, 0, 0, 1, 0);
        chk("lu_after_pc_en", hz.pc_en, 1);
        chk("lu_after_stalls", hz.stall_cycles, 1);
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        chk("x0_pc_en", hz.pc_en, 1);
        chk("x0_id_ex_en", hz.id_ex_en, 1);
        drive(3, 7, 0, 1, 7, 0, 1, 0);
        chk("rs2_unused_pc_en", hz.pc_en, 1);
        drive(3, 7, 1, 1, 7, 0, 1, 0);
        chk("rs2_used_pc_en", hz.pc_en, 0);
        chk("rs2_used_bubble", hz.ex_mem_bubble, 1);
        idle();

        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            chk("mw_pc_en", hz.pc_en, 0);
            chk("mw_bubble", hz.ex_mem_bubble, 0);
        end
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk("mw_ready_pc_en", hz.pc_en, 1);
        chk("mw_stalls", hz.stall_cycles, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_back_to_run", hz.pc_en, 1);

        drive(5, 0, 0, 1, 5, 0, 1, 1);
        chk("br_lu_bubble", hz.ex_mem_bubble, 1);
        chk("br_lu_no_flush", hz.if_id_flush, 0);
        idle();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("br_if_id_flush", hz.if_id_flush, 1);
        chk("br_id_ex_flush", hz.id_ex_flush, 1);
        chk("br_pc_en", hz.pc_en, 1);
        idle();
        chk("br_flush_clears", hz.if_id_flush, 0);

        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            chk("to_pc_en", hz.pc_en, 0);
            if (i == 3) chk("to_err_before", hz.mem_timeout_err, 0);
            if (i == 4) chk("to_err_rise", hz.mem_timeout_err, 1);
        end
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk("to_ready_pc_en", hz.pc_en, 1);
        chk("to_err_sticky", hz.mem_timeout_err, 1);
        idle();
        chk("to_err_sticky2", hz.mem_timeout_err, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc_en", hz.pc_en, 1);
        chk("midrst_stalls", hz.stall_cycles, 0);
        chk("midrst_err", hz.mem_timeout_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_run", hz.pc_en, 1);

        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 299) != 0);
            hz.ID_EX_rs1 = 5'($urandom_range(0, 3));
            hz.ID_EX_rs2 = 5'($urandom_range(0, 3));
            hz.ID_EX_use_rs2 = 1'($urandom_range(0, 1));
            hz.EX_MEM_memread = ($urandom_range(0, 2) != 0);
            hz.EX_MEM_regwrite = ($urandom_range(0, 3) != 0);
            hz.EX_MEM_rd = 5'($urandom_range(0, 3));
            hz.dmem_req = ($urandom_range(0, 2) == 0);
            hz.branch_taken = ($urandom_range(0, 3) == 0);
            if (burst > 0) begin
                hz.dmem_ready = 1'b0;
                burst--;
            end else begin
                if ($urandom_range(0, 19) == 0) burst = $urandom_range(1, 8);
                hz.dmem_ready = ($urandom_range(0, 3) != 0);
            end
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
